// File: rtl/seg_display_if.sv
// Digit/brightness/blank inputs and segment/enable outputs of the two-digit
// seven-segment scheduler, bundled for upstream (master) and scheduler (slave).
interface seg_display_if;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic       digitValid;
    logic [2:0] brightness;
    logic       blank1;
    logic       blank2;
    logic [6:0] sevenSeg;
    logic       enable1;
    logic       enable2;
    logic       frameStart;

    modport master (
        output digit1, digit2, digitValid, brightness, blank1, blank2,
        input  sevenSeg, enable1, enable2, frameStart
    );

    modport slave (
        input  digit1, digit2, digitValid, brightness, blank1, blank2,
        output sevenSeg, enable1, enable2, frameStart
    );
endinterface

// File: rtl/seg_display_scheduler.sv
// Two-digit common-anode display scheduler: SHOW1/DEAD1/SHOW2/DEAD2 frame with
// per-slot PWM and digit/brightness/blank updates only at the frame boundary.
module seg_display_scheduler #(
    parameter int ONBITS     = 8,
    parameter int DEADCYCLES = 4
) (
    input  logic          clk1,
    input  logic          reset,
    seg_display_if.slave  bus
);
    typedef enum logic [1:0] {SHOW1, DEAD1, SHOW2, DEAD2} state_e;

    localparam logic [ONBITS-1:0] SLOT_LAST = {ONBITS{1'b1}};
    localparam logic [ONBITS-1:0] DEAD_LAST = ONBITS'(DEADCYCLES - 1);

    state_e            state_q, state_d;
    logic [ONBITS-1:0] cnt_q, cnt_d;
    logic              frame_end;
    logic [7:0]        pend_q, disp_q;
    logic [2:0]        bright_q;
    logic              blank1_q, blank2_q;
    logic [6:0]        seg_q, seg_d;
    logic              en1_q, en1_d, en2_q, en2_d, fs_q, fs_d;
    logic [2:0]        duty;
    logic              lit1, lit2;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0011000;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b0100111;
            4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + ONBITS'(1);
        frame_end = 1'b0;
        case (state_q)
            SHOW1: if (cnt_q == SLOT_LAST) begin state_d = DEAD1; cnt_d = '0; end
            DEAD1: if (cnt_q == DEAD_LAST) begin state_d = SHOW2; cnt_d = '0; end
            SHOW2: if (cnt_q == SLOT_LAST) begin state_d = DEAD2; cnt_d = '0; end
            default: if (cnt_q == DEAD_LAST) begin
                state_d   = SHOW1;
                cnt_d     = '0;
                frame_end = 1'b1;
            end
        endcase
    end

    // Top three counter bits give the position within the slot in eighths.
    assign duty = cnt_q[ONBITS-1 -: 3];
    assign lit1 = (state_q == SHOW1) && (duty <= bright_q) && !blank1_q;
    assign lit2 = (state_q == SHOW2) && (duty <= bright_q) && !blank2_q;

    always_comb begin
        en1_d = lit1;
        en2_d = lit2;
        fs_d  = (state_q == SHOW1) && (cnt_q == '0);
        seg_d = 7'h7F;
        if (lit1)      seg_d = decode(disp_q[3:0]);
        else if (lit2) seg_d = decode(disp_q[7:4]);
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            state_q  <= SHOW1;
            cnt_q    <= '0;
            pend_q   <= '0;
            disp_q   <= '0;
            bright_q <= '0;
            blank1_q <= 1'b0;
            blank2_q <= 1'b0;
            seg_q    <= 7'h7F;
            en1_q    <= 1'b0;
            en2_q    <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            en1_q   <= en1_d;
            en2_q   <= en2_d;
            fs_q    <= fs_d;
            // Display takes the pending value held before this edge; a same-cycle load waits a frame.
            if (frame_end) begin
                disp_q   <= pend_q;
                bright_q <= bus.brightness;
                blank1_q <= bus.blank1;
                blank2_q <= bus.blank2;
            end
            if (bus.digitValid) pend_q <= {bus.digit2, bus.digit1};
        end
    end

    assign bus.sevenSeg   = seg_q;
    assign bus.enable1    = en1_q;
    assign bus.enable2    = en2_q;
    assign bus.frameStart = fs_q;
endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler with a frame-position reference model
// feeding an expected-output queue compared every cycle.
module tb_seg_display_scheduler;
    localparam int ONB   = 3;
    localparam int DC    = 2;
    localparam int SLOT  = 1 << ONB;
    localparam int FRAME = 2 * SLOT + 2 * DC;

    logic clk1 = 1'b0;
    logic reset;
    always #5 clk1 = ~clk1;

    seg_display_if bus ();

    seg_display_scheduler #(.ONBITS(ONB), .DEADCYCLES(DC)) dut (
        .clk1  (clk1),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    int         mpos;
    logic [7:0] mpend, mdisp;
    logic [2:0] mbr;
    logic       mb1, mb2;
    logic [9:0] exp_q[$];

    int         n1, n2, nfs;
    logic [6:0] seg1, seg2;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};
        return t[d];
    endfunction

    // Expected {frameStart, enable1, enable2, sevenSeg} after the coming edge.
    function automatic logic [9:0] model_out();
        int   idx;
        logic l1, l2;
        if (reset) return {3'b000, 7'h7F};
        l1 = 1'b0;
        l2 = 1'b0;
        if (mpos < SLOT) begin
            idx = mpos;
            l1  = ((idx >> (ONB - 3)) <= int'(mbr)) && !mb1;
        end else if (mpos >= SLOT + DC && mpos < 2 * SLOT + DC) begin
            idx = mpos - SLOT - DC;
            l2  = ((idx >> (ONB - 3)) <= int'(mbr)) && !mb2;
        end
        return {mpos == 0, l1, l2, l1 ? seg_of(mdisp[3:0]) : l2 ? seg_of(mdisp[7:4]) : 7'h7F};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clr();
        n1 = 0; n2 = 0; nfs = 0; seg1 = 7'h7F; seg2 = 7'h7F;
    endtask

    task automatic step();
        logic [9:0] obs, expv;
        exp_q.push_back(model_out());
        @(posedge clk1);
        #1;
        obs  = {bus.frameStart, bus.enable1, bus.enable2, bus.sevenSeg};
        expv = exp_q.pop_front();
        chk("cycle", {22'd0, obs}, {22'd0, expv});
        if (bus.enable1) begin n1++; seg1 = bus.sevenSeg; end
        if (bus.enable2) begin n2++; seg2 = bus.sevenSeg; end
        if (bus.frameStart) nfs++;
        if (reset) begin
            mpos = 0; mpend = '0; mdisp = '0; mbr = '0; mb1 = 1'b0; mb2 = 1'b0;
        end else begin
            if (mpos == FRAME - 1) begin
                mdisp = mpend;
                mbr   = bus.brightness;
                mb1   = bus.blank1;
                mb2   = bus.blank2;
            end
            if (bus.digitValid) mpend = {bus.digit2, bus.digit1};
            mpos = (mpos + 1) % FRAME;
        end
    endtask

    initial begin
        mpos = 0; mpend = '0; mdisp = '0; mbr = '0; mb1 = 1'b0; mb2 = 1'b0;
        reset = 1'b1;
        bus.digit1 = 4'h0; bus.digit2 = 4'h0; bus.digitValid = 1'b0;
        bus.brightness = 3'd0; bus.blank1 = 1'b0; bus.blank2 = 1'b0;

        // Reset and first frame: 0,0 at 1/8 brightness
        clr();
        repeat (3) step();
        chk("rst_en", n1 + n2 + nfs, 0);
        reset = 1'b0;
        clr();
        repeat (FRAME) step();
        chk("f1_en1", n1, 1);
        chk("f1_en2", n2, 1);
        chk("f1_seg1", seg1, 7'h40);
        chk("f1_fs", nfs, 1);

        // Load 3/A at full brightness; visible next frame
        bus.digit1 = 4'h3; bus.digit2 = 4'hA; bus.brightness = 3'd7; bus.digitValid = 1'b1;
        clr();
        step();
        bus.digitValid = 1'b0;
        repeat (FRAME - 1) step();
        chk("f2_en1", n1, 1);
        chk("f2_seg1", seg1, 7'h40);

        bus.brightness = 3'd2;
        clr();
        repeat (FRAME) step();
        chk("full_en1", n1, SLOT);
        chk("full_en2", n2, SLOT);
        chk("full_seg1", seg1, 7'h30);
        chk("full_seg2", seg2, 7'h08);

        // PWM at brightness 2: 3 of 8 cycles lit
        clr();
        repeat (FRAME) step();
        chk("pwm_en1", n1, 3);
        chk("pwm_en2", n2, 3);

        // Loads mid-SHOW2 and in the last DEAD2 cycle
        clr();
        repeat (SLOT + DC + 2) step();
        bus.digit1 = 4'h5; bus.digitValid = 1'b1;
        step();
        bus.digitValid = 1'b0;
        repeat (FRAME - (SLOT + DC + 2) - 2) step();
        bus.digit1 = 4'h9; bus.digitValid = 1'b1;
        step();
        bus.digitValid = 1'b0;
        chk("align_hold", seg1, 7'h30);
        chk("align_pos", mpos, 0);

        bus.blank2 = 1'b1;
        clr();
        repeat (FRAME) step();
        chk("align_5", seg1, 7'h12);
        chk("pre_blank_en2", n2, 3);

        // Blanked digit 2, then reset at SHOW2 cnt=4
        clr();
        repeat (SLOT + DC + 4) step();
        chk("align_9", seg1, 7'h18);
        chk("blank_en2", n2, 0);
        reset = 1'b1;
        clr();
        step();
        chk("midrst_out", n1 + n2 + nfs, 0);
        reset = 1'b0;
        bus.blank2 = 1'b0;
        clr();
        repeat (FRAME) step();
        chk("restart_en1", n1, 1);
        chk("restart_seg1", seg1, 7'h40);
        chk("restart_fs", nfs, 1);

        // Pending capture was discarded by reset: digits stay 0
        clr();
        repeat (FRAME) step();
        chk("discard_seg1", seg1, 7'h40);
        chk("discard_en1", n1, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
